// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-transmitter signal bundle for uart_tx_arbiter.
// The slave view is the arbiter; the master view drives requests and models the UART.
interface uart_tx_arbiter_if #(
    parameter int unsigned DATA_LEN = 8,
    parameter int unsigned NUM_REQ  = 4
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*DATA_LEN-1:0] req_data;
    logic [NUM_REQ-1:0]          grant;
    logic [NUM_REQ-1:0]          done;
    logic [NUM_REQ-1:0]          err;
    logic                        u_tx_busy;
    logic                        u_tx_done;
    logic                        u_send_sig;
    logic [DATA_LEN-1:0]         u_data_out;

    modport master (
        output req, req_data, u_tx_busy, u_tx_done,
        input  grant, done, err, u_send_sig, u_data_out
    );

    modport slave (
        input  req, req_data, u_tx_busy, u_tx_done,
        output grant, done, err, u_send_sig, u_data_out
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Each grant sends exactly one byte, then completes with done or, on watchdog
// expiry, with err. All outputs are registered.
module uart_tx_arbiter #(
    parameter int unsigned DATA_LEN  = 8,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_COUNT = 50000
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    // One extra count of headroom so MAX_COUNT itself is representable.
    localparam int unsigned WD_W  = $clog2(MAX_COUNT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_COUNT - 1);

    typedef enum logic [1:0] {StIdle, StSend, StWaitTx, StRelease} state_e;

    state_e              state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [NUM_REQ-1:0]  done_q;
    logic [NUM_REQ-1:0]  err_q;
    logic                send_sig_q;
    logic [DATA_LEN-1:0] data_q;
    logic [WD_W-1:0]     wdog_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    owner_q;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    cand_idx;
    logic [NUM_REQ-1:0]  pick_onehot;

    // Round-robin pick: scan from ptr+1 upward, wrapping; ptr itself is tried last.
    // Index arithmetic wraps naturally because NUM_REQ is a power of two (fixed 4).
    always_comb begin
        pick_valid  = 1'b0;
        pick_idx    = '0;
        cand_idx    = '0;
        pick_onehot = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            cand_idx = ptr_q + IDX_W'(i);
            if (!pick_valid && bus.req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
        pick_onehot[pick_idx] = 1'b1;
    end

    // Arbitration FSM with registered grant, pulses, data and watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            done_q     <= '0;
            err_q      <= '0;
            send_sig_q <= 1'b0;
            data_q     <= '0;
            wdog_q     <= '0;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            owner_q    <= '0;
        end else begin
            send_sig_q <= 1'b0;
            done_q     <= '0;
            err_q      <= '0;
            case (state_q)
                StIdle: begin
                    if (pick_valid && !bus.u_tx_busy) begin
                        grant_q    <= pick_onehot;
                        owner_q    <= pick_idx;
                        data_q     <= bus.req_data[pick_idx*DATA_LEN +: DATA_LEN];
                        send_sig_q <= 1'b1;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    // Completion pulses this early belong to nobody and are dropped.
                    wdog_q  <= '0;
                    state_q <= StWaitTx;
                end
                StWaitTx: begin
                    if (bus.u_tx_done) begin
                        // Completion takes priority over a coincident expiry.
                        done_q  <= grant_q;
                        state_q <= StRelease;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                        if (wdog_q == WD_LAST) begin
                            err_q   <= grant_q;
                            state_q <= StRelease;
                        end
                    end
                end
                StRelease: begin
                    grant_q <= '0;
                    ptr_q   <= owner_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.u_send_sig = send_sig_q;
    assign bus.u_data_out = data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a transaction-level model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_arbiter;
    localparam int unsigned DATA_LEN  = 8;
    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned MAX_COUNT = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.DATA_LEN(DATA_LEN), .NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .DATA_LEN (DATA_LEN),
        .NUM_REQ  (NUM_REQ),
        .MAX_COUNT(MAX_COUNT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A served requester is tracked as: sent (start pulse issued), waits (WAIT
    // cycles observed), finished (done/err issued, grant drops next cycle).
    bit         m_valid = 1'b0;
    bit         m_busy, m_sent, m_fin;
    int         m_owner, m_waits, m_last, m_cand;
    logic [3:0] e_grant, e_done, e_err;
    logic       e_send;
    logic [7:0] e_data;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_last  = 3;
            e_grant = '0;
            e_done  = '0;
            e_err   = '0;
            e_send  = 1'b0;
            e_data  = '0;
        end else begin
            e_done = '0;
            e_err  = '0;
            e_send = 1'b0;
            if (!m_busy) begin
                if (bus.req != 0 && !bus.u_tx_busy) begin
                    for (int k = 1; k <= 4; k++) begin
                        m_cand = (m_last + k) % 4;
                        if (!m_busy && bus.req[m_cand]) begin
                            m_busy  = 1'b1;
                            m_owner = m_cand;
                        end
                    end
                    m_sent  = 1'b0;
                    m_fin   = 1'b0;
                    m_waits = 0;
                    e_grant = 4'(1 << m_owner);
                    e_send  = 1'b1;
                    e_data  = bus.req_data[m_owner*8 +: 8];
                end
            end else if (m_fin) begin
                e_grant = '0;
                m_last  = m_owner;
                m_busy  = 1'b0;
            end else if (!m_sent) begin
                m_sent = 1'b1;
            end else begin
                m_waits++;
                if (bus.u_tx_done) begin
                    e_done = e_grant;
                    m_fin  = 1'b1;
                end else if (m_waits == MAX_COUNT) begin
                    e_err = e_grant;
                    m_fin = 1'b1;
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("m_grant", bus.grant, e_grant);
            check("m_done", bus.done, e_done);
            check("m_err", bus.err, e_err);
            check("m_send", bus.u_send_sig, e_send);
            check("m_data", bus.u_data_out, e_data);
            check("grant_onehot0", $onehot0(bus.grant), 1);
            check("done_onehot0", $onehot0(bus.done), 1);
            check("err_onehot0", $onehot0(bus.err), 1);
            check("done_err_excl", (bus.done != 0) && (bus.err != 0), 0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_send(input string name, input int exp_n);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 30) begin
            step(1);
            n++;
            seen = (bus.u_send_sig === 1'b1);
        end
        check({name, "_latency"}, n, exp_n);
    endtask

    task automatic finish_byte();
        step(3);
        bus.u_tx_done = 1'b1;
        step(1);
        bus.u_tx_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    logic [3:0] rr_order [5];
    logic [7:0] rr_bytes [5];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        bit seen;
        rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        bus.req       = '0;
        bus.req_data  = '0;
        bus.u_tx_busy = 1'b0;
        bus.u_tx_done = 1'b0;
        step(3);
        reset = 1'b0;
        check("rst_grant", bus.grant, 4'b0000);
        check("rst_send", bus.u_send_sig, 1'b0);
        check("rst_data", bus.u_data_out, 8'h00);
        check("rst_done_err", {bus.done, bus.err}, 8'h00);

        // Single byte; owner drops req mid-transfer and still gets done.
        bus.req_data = 32'h0000_00A5;
        bus.req      = 4'b0001;
        wait_send("t1_send", 1);
        check("t1_grant", bus.grant, 4'b0001);
        check("t1_data", bus.u_data_out, 8'hA5);
        bus.req       = 4'b0000;
        bus.u_tx_busy = 1'b1;
        step(1);
        check("t1_send_low", bus.u_send_sig, 1'b0);
        step(6);
        bus.u_tx_busy = 1'b0;
        bus.u_tx_done = 1'b1;
        step(1);
        bus.u_tx_done = 1'b0;
        check("t1_done", bus.done, 4'b0001);
        step(1);
        check("t1_release", bus.grant, 4'b0000);

        // All four requesting: strict rotation, two-cycle spacing after done.
        do_reset();
        bus.req_data = 32'h4433_2211;
        bus.req      = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_send("t2_send", (k == 0) ? 1 : 2);
            check("t2_grant", bus.grant, rr_order[k]);
            check("t2_data", bus.u_data_out, rr_bytes[k]);
            finish_byte();
            check("t2_done", bus.done, rr_order[k]);
            if (k == 4) bus.req = 4'b0000;
        end
        step(2);

        // Transmitter busy holds off the grant.
        bus.u_tx_busy = 1'b1;
        bus.req_data  = 32'h0077_0000;
        bus.req       = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check("t3_busy_grant", bus.grant, 4'b0000);
            check("t3_busy_send", bus.u_send_sig, 1'b0);
        end
        bus.u_tx_busy = 1'b0;
        wait_send("t3_send", 1);
        check("t3_grant", bus.grant, 4'b0100);
        check("t3_data", bus.u_data_out, 8'h77);
        bus.req = 4'b0000;
        finish_byte();
        step(2);

        // Watchdog: err after 16 full WAIT_TX cycles, i.e. 17 cycles after the
        // start pulse.
        bus.req_data = 32'h0000_5A00;
        bus.req      = 4'b0010;
        wait_send("t4_send", 1);
        check("t4_grant", bus.grant, 4'b0010);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            step(1);
            n++;
            seen = (bus.err != 0);
        end
        check("t4_err_latency", n, 17);
        check("t4_err", bus.err, 4'b0010);
        check("t4_no_done", bus.done, 4'b0000);
        bus.req = 4'b0000;
        step(1);
        check("t4_release", bus.grant, 4'b0000);
        step(1);

        // Completion coinciding with expiry: done wins.
        bus.req_data = 32'hC300_0000;
        bus.req      = 4'b1000;
        wait_send("t5_send", 1);
        step(16);
        bus.u_tx_done = 1'b1;
        step(1);
        bus.u_tx_done = 1'b0;
        check("t5_done", bus.done, 4'b1000);
        check("t5_no_err", bus.err, 4'b0000);
        bus.req = 4'b0000;
        step(2);

        // Completion pulses in IDLE/SEND ignored; req_data changes ignored.
        bus.u_tx_done = 1'b1;
        step(1);
        bus.u_tx_done = 1'b0;
        check("t6_idle_done", bus.done, 4'b0000);
        check("t6_idle_grant", bus.grant, 4'b0000);
        bus.req_data = 32'h0000_0096;
        bus.req      = 4'b0001;
        wait_send("t6_send", 1);
        bus.req_data  = 32'hFFFF_FFFF;
        bus.u_tx_done = 1'b1;
        step(1);
        bus.u_tx_done = 1'b0;
        check("t6_send_done", bus.done, 4'b0000);
        check("t6_hold_grant", bus.grant, 4'b0001);
        finish_byte();
        check("t6_done", bus.done, 4'b0001);
        check("t6_hold_data", bus.u_data_out, 8'h96);
        bus.req = 4'b0000;
        step(2);

        // Reset during WAIT_TX abandons the owner silently.
        bus.req_data = 32'h00E1_0000;
        bus.req      = 4'b0100;
        wait_send("t7_send", 1);
        step(3);
        reset   = 1'b1;
        bus.req = 4'b0000;
        step(1);
        reset = 1'b0;
        check("t7_rst_outs", {bus.grant, bus.done, bus.err, 7'd0, bus.u_send_sig}, 32'h0);
        check("t7_rst_data", bus.u_data_out, 8'h00);
        bus.u_tx_done = 1'b1;
        step(1);
        bus.u_tx_done = 1'b0;
        check("t7_post_outs", {bus.grant, bus.done, bus.err, 7'd0, bus.u_send_sig}, 32'h0);
        bus.req_data = 32'h0000_3C00;
        bus.req      = 4'b0010;
        wait_send("t7_send2", 1);
        check("t7_grant", bus.grant, 4'b0010);
        check("t7_data", bus.u_data_out, 8'h3C);
        finish_byte();
        check("t7_done", bus.done, 4'b0010);
        bus.req = 4'b0000;
        step(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter DATA_LEN, default 8, meaning UART byte width.
REQ-002 SHALL have parameter NUM_REQ, default 4, meaning number of requesters (fixed at 4 in this revision).
REQ-003 SHALL have parameter MAX_COUNT, default 50000, meaning the watchdog limit in clk cycles for one byte.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port req, input, 4, per-requester send request, held high until that requester's done or err.
REQ-007 SHALL have port req_data, input, 4*DATA_LEN, byte of requester i at bits [i*DATA_LEN +: DATA_LEN].
REQ-008 SHALL have port grant, output, 4, one-hot owner of the transmitter, 0 when idle.
REQ-009 SHALL have port done, output, 4, one-cycle pulse to the owner on successful transmission.
REQ-010 SHALL have port err, output, 4, one-cycle pulse to the owner on watchdog expiry.
REQ-011 SHALL have port u_tx_busy, input, 1, UART transmitter busy.
REQ-012 SHALL have port u_tx_done, input, 1, UART transmitter one-cycle completion pulse.
REQ-013 SHALL have port u_send_sig, output, 1, one-cycle start pulse to the UART transmitter.
REQ-014 SHALL have port u_data_out, output, DATA_LEN, byte presented to the UART transmitter.

Function
REQ-015 SHALL implement the states IDLE, SEND, WAIT_TX and RELEASE.
REQ-016 In IDLE, when req!=0 and u_tx_busy==0, SHALL select a requester round-robin, starting at ptr+1 mod 4 and wrapping.
REQ-017 On selection, SHALL register grant (one-hot), latch u_data_out from the winner's req_data, pulse u_send_sig, and enter SEND; all take effect the cycle after the request is sampled.
REQ-018 In IDLE with u_tx_busy==1, SHALL not grant and SHALL keep u_send_sig=0.
REQ-019 SEND SHALL last exactly one cycle: u_send_sig returns to 0, the watchdog clears to 0, and the FSM enters WAIT_TX.
REQ-020 In WAIT_TX, on u_tx_done==1, SHALL pulse done[owner] for one cycle and enter RELEASE.
REQ-021 In WAIT_TX without u_tx_done, the watchdog SHALL increment; on reaching MAX_COUNT it SHALL pulse err[owner] and enter RELEASE.
REQ-022 If u_tx_done and watchdog expiry coincide, done SHALL win and err SHALL stay 0.
REQ-023 RELEASE SHALL last one cycle: grant cleared to 0, ptr set to the owner index, return to IDLE; a requester still asserting req there is not re-served before lower-priority pending requesters.
REQ-024 u_data_out and grant SHALL stay stable from SEND through RELEASE; req_data changes in that window SHALL be ignored.
REQ-025 The owner deasserting req during SEND/WAIT_TX SHALL NOT abort the byte; completion still pulses done.
REQ-026 At most one bit of grant, done and err SHALL be high in any cycle; done and err SHALL never be high together.
REQ-027 Minimum back-to-back spacing: a request pending in RELEASE SHALL get u_send_sig 2 cycles after the prior done pulse.
REQ-028 u_tx_done while in IDLE or SEND SHALL be ignored.
REQ-029 The watchdog counter SHALL be wide enough for MAX_COUNT without wrap-around.

Reset
REQ-030 While reset==1 at a clk edge: state=IDLE, grant=0, done=0, err=0, u_send_sig=0, u_data_out=0, watchdog=0, ptr=3 (so requester 0 has first priority).
REQ-031 Reset mid-transmission SHALL abandon the owner silently: no done/err pulse, no u_send_sig on the following cycle.

Verification
REQ-032 After reset, req=4'b0001, req_data[7:0]=8'hA5, u_tx_done 20 cycles later -> grant=0001 and u_send_sig pulse with u_data_out=A5 one cycle after req; done[0] one cycle after u_tx_done; grant=0 next cycle.
REQ-033 req=4'b1111 held, each byte completed -> grant order 0001,0010,0100,1000,0001; no requester served twice consecutively.
REQ-034 req=4'b0100 while u_tx_busy=1 for 10 cycles -> no grant, no u_send_sig until one cycle after u_tx_busy falls.
REQ-035 Grant to requester 1, u_tx_done withheld, MAX_COUNT=16 -> err[1] pulse 16 cycles after SEND, done stays 0, grant cleared next cycle.
REQ-036 reset asserted during WAIT_TX, then u_tx_done pulsed -> all outputs 0, no done/err pulse, IDLE; next req=0010 with req_data=8'h3C is served normally.
